// File: rtl/num_line_formatter.sv
// num_line_formatter: accumulates ASCII decimal digits into a saturating
// value and echoes each line as canonical decimal text followed by CR LF.
module num_line_formatter #(
  parameter int unsigned MaxValue = 65535
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       Overflow
);

  typedef enum logic [2:0] {
    S_RST,
    S_ACCUM,
    S_CONV,
    S_EMIT,
    S_EMIT_CR,
    S_EMIT_LF
  } state_e;

  localparam logic [15:0] MaxV = 16'(MaxValue);
  localparam logic [7:0]  ChCr = 8'h0D;
  localparam logic [7:0]  ChLf = 8'h0A;
  localparam logic [7:0]  ChQm = 8'h3F;
  localparam logic [7:0]  Ch0  = 8'h30;

  state_e      state_q, state_d;
  logic [15:0] value_q, value_d;
  logic [15:0] rem_q, rem_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic [2:0]  k_q, k_d;
  logic [3:0]  digit_q, digit_d;
  logic        err_q, err_d;
  logic        sat_q, sat_d;
  logic        started_q, started_d;
  logic [7:0]  dout_q, dout_d;
  logic        vld_q, vld_d;
  logic        ovf_q, ovf_d;

  logic [19:0] next_val;
  logic [15:0] pow_k;
  logic        is_digit;

  always_comb begin
    case (k_q)
      3'd0:    pow_k = 16'd10000;
      3'd1:    pow_k = 16'd1000;
      3'd2:    pow_k = 16'd100;
      3'd3:    pow_k = 16'd10;
      default: pow_k = 16'd1;
    endcase
  end

  assign is_digit = (DataIn >= 8'h30) && (DataIn <= 8'h39);
  assign next_val = 20'(value_q) * 20'd10 + 20'(DataIn[3:0]);

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    rem_d     = rem_q;
    dcnt_d    = dcnt_q;
    k_d       = k_q;
    digit_d   = digit_q;
    err_d     = err_q;
    sat_d     = sat_q;
    started_d = started_q;
    dout_d    = dout_q;
    ovf_d     = 1'b0;

    unique case (state_q)
      S_RST: state_d = S_ACCUM;

      S_ACCUM: begin
        if (DataInValid) begin
          if (is_digit) begin
            if (next_val > 20'(MaxV)) begin
              value_d = MaxV;
              sat_d   = 1'b1;
            end else begin
              value_d = next_val[15:0];
            end
            if (dcnt_q != 3'd6) dcnt_d = dcnt_q + 3'd1;
          end else if (DataIn == ChLf) begin
            state_d = S_ACCUM;
          end else if (DataIn == ChCr) begin
            if (err_q) begin
              dout_d  = ChQm;
              state_d = S_EMIT;
            end else if (dcnt_q == 3'd0) begin
              dout_d  = ChCr;
              state_d = S_EMIT_CR;
            end else begin
              rem_d     = value_q;
              k_d       = 3'd0;
              digit_d   = 4'd0;
              started_d = 1'b0;
              state_d   = S_CONV;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      // One subtract or one resolve per cycle; leading zeros are skipped
      S_CONV: begin
        if (rem_q >= pow_k) begin
          rem_d   = rem_q - pow_k;
          digit_d = digit_q + 4'd1;
        end else if (digit_q != 4'd0 || started_q || k_q == 3'd4) begin
          dout_d    = Ch0 + {4'd0, digit_q};
          started_d = 1'b1;
          state_d   = S_EMIT;
        end else begin
          k_d     = k_q + 3'd1;
          digit_d = 4'd0;
        end
      end

      S_EMIT: begin
        if (DataOutReady) begin
          if (err_q || k_q == 3'd4) begin
            dout_d  = ChCr;
            state_d = S_EMIT_CR;
          end else begin
            k_d     = k_q + 3'd1;
            digit_d = 4'd0;
            state_d = S_CONV;
          end
        end
      end

      S_EMIT_CR: begin
        if (DataOutReady) begin
          dout_d  = ChLf;
          state_d = S_EMIT_LF;
        end
      end

      S_EMIT_LF: begin
        if (DataOutReady) begin
          ovf_d   = sat_q && !err_q;
          value_d = 16'd0;
          dcnt_d  = 3'd0;
          err_d   = 1'b0;
          sat_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end

      default: state_d = S_RST;
    endcase

    vld_d = (state_d == S_EMIT) || (state_d == S_EMIT_CR) ||
            (state_d == S_EMIT_LF);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_RST;
      value_q   <= 16'd0;
      rem_q     <= 16'd0;
      dcnt_q    <= 3'd0;
      k_q       <= 3'd0;
      digit_q   <= 4'd0;
      err_q     <= 1'b0;
      sat_q     <= 1'b0;
      started_q <= 1'b0;
      dout_q    <= 8'h00;
      vld_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      rem_q     <= rem_d;
      dcnt_q    <= dcnt_d;
      k_q       <= k_d;
      digit_q   <= digit_d;
      err_q     <= err_d;
      sat_q     <= sat_d;
      started_q <= started_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign DataInReady  = (state_q == S_ACCUM);
  assign DataOut      = dout_q;
  assign DataOutValid = vld_q;
  assign Overflow     = ovf_q;

endmodule

// File: tb/tb_num_line_formatter.sv
// tb_num_line_formatter: directed and random lines checked against a
// line-level reference model of the decimal echo.
module tb_num_line_formatter;

  localparam int MAXV = 65535;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic       DataInValid = 1'b0;
  logic       DataInReady;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady = 1'b1;
  logic       Overflow;

  always #5 Clock = ~Clock;

  num_line_formatter #(.MaxValue(MAXV)) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .DataIn      (DataIn),
    .DataInValid (DataInValid),
    .DataInReady (DataInReady),
    .DataOut     (DataOut),
    .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady),
    .Overflow    (Overflow)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int cr_cyc = 0;
  int exp_lat = 0;
  int last_lat = -1;
  int ovf_cnt = 0;
  bit busy = 0;
  bit lat_pend = 0;
  bit stall_pend = 0;
  bit after_rst = 1;
  bit exp_ovf = 0;
  bit line_ovf = 0;
  bit rand_ready = 0;
  logic [7:0] stall_byte = 8'h00;
  logic [7:0] mon_e;
  logic [7:0] exp_q[$];
  logic [7:0] cap[$];

  int l_val = 0;
  int l_dig = 0;
  bit l_err = 0;
  bit l_sat = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act,
                       input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  function automatic string cap_hex();
    string s = "";
    foreach (cap[i]) s = {s, $sformatf("%02h", cap[i])};
    return s;
  endfunction

  task automatic line_clear();
    l_val = 0;
    l_dig = 0;
    l_err = 0;
    l_sat = 0;
  endtask

  // Expected echo for a terminated line, from its accepted bytes
  task automatic model_cr();
    string s;
    if (l_err) begin
      exp_q.push_back(8'h3F);
      exp_lat = 1;
      line_ovf = 0;
    end else if (l_dig == 0) begin
      exp_lat = 1;
      line_ovf = 0;
    end else begin
      s = $sformatf("%0d", l_val);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_lat = 5 - s.len() + (int'(s[0]) - 48) + 2;
      line_ovf = l_sat;
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    busy = 1;
    lat_pend = 1;
    cr_cyc = cyc;
    line_clear();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) begin
      l_dig++;
      l_val = l_val * 10 + (int'(b) - 48);
      if (l_val > MAXV) begin
        l_val = MAXV;
        l_sat = 1;
      end
    end else if (b == 8'h0D) begin
      model_cr();
    end else if (b != 8'h0A) begin
      l_err = 1;
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset_n) begin
      exp_q.delete();
      busy = 0;
      lat_pend = 0;
      stall_pend = 0;
      exp_ovf = 0;
      after_rst = 1;
      line_clear();
    end else begin
      cyc++;
      chk("overflow", Overflow, exp_ovf);
      if (Overflow === 1'b1) ovf_cnt++;
      exp_ovf = 0;
      chk("in_ready", DataInReady, !busy && !after_rst);
      after_rst = 0;
      if (!busy) chk("out_valid_idle", DataOutValid, 1'b0);
      if (stall_pend) begin
        chk("stall_valid", DataOutValid, 1'b1);
        chk("stall_data", DataOut, stall_byte);
      end
      if (DataInValid && DataInReady) model_byte(DataIn);
      stall_pend = 0;
      if (DataOutValid) begin
        if (lat_pend) begin
          last_lat = cyc - cr_cyc;
          chk("first_valid_latency", last_lat, exp_lat);
          lat_pend = 0;
        end
        if (DataOutReady) begin
          cap.push_back(DataOut);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL out_unexpected: got %02h expected none", DataOut);
          end else begin
            mon_e = exp_q.pop_front();
            chk("out_byte", DataOut, mon_e);
            if (exp_q.size() == 0) begin
              busy = 0;
              exp_ovf = line_ovf;
            end
          end
        end else begin
          stall_pend = 1;
          stall_byte = DataOut;
        end
      end
    end
  end

  always @(posedge Clock) begin
    #1;
    DataOutReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    DataIn = b;
    DataInValid = 1'b1;
    @(negedge Clock);
    while (!DataInReady && n < 500) begin
      @(negedge Clock);
      n++;
    end
    chk("send_ready", DataInReady, 1'b1);
    @(posedge Clock);
    #1;
  endtask

  // '|' stands for CR and '^' for LF
  task automatic send_str(input string s, input bit hold);
    logic [7:0] b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      if (b == "|") b = 8'h0D;
      else if (b == "^") b = 8'h0A;
      send(b);
    end
    if (!hold) DataInValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge Clock);
      n++;
    end
    chk("drain_bound", n < 3000, 1'b1);
    repeat (3) @(negedge Clock);
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_in_ready"}, DataInReady, 1'b0);
    chk({tag, "_out_valid"}, DataOutValid, 1'b0);
    chk({tag, "_out_data"}, DataOut, 8'h00);
    chk({tag, "_overflow"}, Overflow, 1'b0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int len;
    int r;
    repeat (3) @(posedge Clock);
    #1;
    chk_outs_zero("reset");
    Reset_n = 1'b1;
    @(posedge Clock);
    #1;

    cap.delete();
    ovf_cnt = 0;
    send_str("42|", 0);
    drain();
    chk_s("line_42", cap_hex(), "34320d0a");
    chk("ovf_42", ovf_cnt, 0);

    cap.delete();
    send_str("0007|", 0);
    drain();
    chk("latency_7", last_lat, 13);
    send_str("^0|", 0);
    drain();
    chk("latency_0", last_lat, 6);
    chk_s("line_7_0", cap_hex(), "370d0a300d0a");

    cap.delete();
    ovf_cnt = 0;
    send_str("99999|", 0);
    drain();
    chk_s("line_sat", cap_hex(), "36353533350d0a");
    chk("ovf_sat_count", ovf_cnt, 1);

    cap.delete();
    ovf_cnt = 0;
    send_str("1a2|", 0);
    drain();
    send_str("|", 0);
    drain();
    chk_s("line_err_empty", cap_hex(), "3f0d0a0d0a");
    chk("ovf_err", ovf_cnt, 0);

    cap.delete();
    rand_ready = 1;
    send_str("31415|", 1);
    DataIn = 8'h0A;
    drain();
    DataInValid = 1'b0;
    rand_ready = 0;
    chk_s("line_stall", cap_hex(), "33313431350d0a");

    send_str("12345|", 0);
    #3;
    Reset_n = 1'b0;
    #1;
    chk_outs_zero("midreset");
    @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    @(negedge Clock);
    chk("rst_cycle_ready", DataInReady, 1'b0);
    @(negedge Clock);
    chk("post_rst_ready", DataInReady, 1'b1);
    @(posedge Clock);
    #1;
    cap.delete();
    send_str("8|", 0);
    drain();
    chk_s("line_after_reset", cap_hex(), "380d0a");

    rand_ready = 1;
    for (int l = 0; l < 80; l++) begin
      len = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        if (r < 80) b = 8'($urandom_range(48, 57));
        else if (r < 88) b = 8'h0A;
        else if (r < 93) b = 8'h30;
        else b = 8'($urandom_range(33, 126));
        if ($urandom_range(0, 3) == 0) begin
          DataInValid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge Clock);
          #1;
        end
        send(b);
      end
      send(8'h0D);
      DataInValid = 1'b0;
      drain();
    end
    rand_ready = 0;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/num_line_formatter.md
# num_line_formatter

Decimal-number line formatter between the UART receive side and the character FIFO in the number-echo datapath. It consumes ASCII bytes and accumulates decimal digits into a saturating 16-bit unsigned value. On carriage return it emits the value's canonical decimal text (leading zeros stripped), followed by CR LF, into the downstream FIFO. Malformed lines produce "?" CR LF.

## Interface
- `MaxValue`, default 65535: saturation ceiling; must be ≤ 65535.
- `Clock` in 1: sole clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `DataIn` in 8: received byte from the UART.
- `DataInValid` in 1: `DataIn` is valid.
- `DataInReady` out 1: block accepts `DataIn` this cycle.
- `DataOut` out 8: ASCII byte to the character FIFO.
- `DataOutValid` out 1: `DataOut` is valid.
- `DataOutReady` in 1: FIFO accepts `DataOut`.
- `Overflow` out 1: one-cycle pulse when a saturated line is terminated.

## Operation
- States: RST, ACCUM, CONV, EMIT, EMIT_CR, EMIT_LF.
- Reset (`Reset_n`=0) forces the following:
  - state=RST, value=0, digit count=0, error flag=0, saturation flag=0.
  - All outputs are 0: `DataInReady`=0, `DataOutValid`=0, `DataOut`=8'h00, `Overflow`=0.
- RST → ACCUM on the first clock after reset deasserts.
- ACCUM: `DataInReady`=1. Each accepted byte (`DataInValid`&`DataInReady`) is handled as follows:
  - '0'..'9' (0x30–0x39):
    - next = value*10 + d, computed in 20 bits.
    - If next > `MaxValue`: value=`MaxValue` and the saturation flag is set. Otherwise value=next.
    - Digit count is incremented, saturating at 6.
  - 0x0A (LF): discarded, no state change.
  - 0x0D (CR): the line ends. Action depends on the line content:
    - Error flag set: load '?' and go to EMIT.
    - Else if digit count=0: go to EMIT_CR (empty line echoes CR LF only).
    - Else: go to CONV with remainder=value, power index k=0, digit=0, started=0.
  - Any other byte: set the error flag and keep absorbing until CR.
- CONV: `DataInReady`=0. Powers P[k] are 10000, 1000, 100, 10, 1. Each cycle does exactly one of the following:
  - If remainder ≥ P[k]: remainder -= P[k], digit++.
  - Else, digit resolved:
    - If digit≠0, started=1, or k=4: load '0'+digit, set started=1, go to EMIT.
    - Otherwise suppress the digit, k++, digit=0.
- EMIT: `DataOutValid`=1.
  - On `DataOutReady`, the next state depends on what was emitted:
    - After '?' or after the k=4 digit: go to EMIT_CR.
    - Otherwise: k++, digit=0, go to CONV.
- EMIT_CR then EMIT_LF: emit 0x0D, then 0x0A, each held until `DataOutReady`.
- After LF is accepted:
  - Clear value, digit count, error flag and saturation flag.
  - `Overflow` pulses for one cycle if the saturation flag was set on this line.
  - Return to ACCUM.
- Saturated lines print `MaxValue`; the error flag takes precedence over saturation (prints "?", no `Overflow` pulse).

## Timing
- `DataOut` and `DataOutValid` are registered.
- `DataOut` stays stable while `DataOutValid`=1 and `DataOutReady`=0.
- `DataOutValid` deasserts the cycle after the last handshake of a byte, unless another emit state follows directly.
- `DataInReady` is 1 only in ACCUM. While a line is being emitted, input backpressures the UART; no bytes are dropped.
- Accept latency in ACCUM is 0: one byte per cycle is sustained.
- CR-to-first-`DataOutValid` latency:
  - (number of resolve/subtract cycles before the first non-suppressed digit) + 1.
  - Value 7: 4 suppressed resolves + 7 subtracts + 1 resolve, so valid rises 13 cycles after the CR handshake.
  - Worst case across one line is ≤ 50 CONV cycles.
- When `DataOutReady` is held 1, consecutive emitted bytes are separated by CONV cycles only; the CR and LF bytes emit back-to-back.
- Asynchronous reset mid-line or mid-emit aborts immediately. No partial character completes; `DataOutValid` drops with reset.

## Test plan
- Input "42\r", `DataOutReady`=1 → output "42\r\n" (0x34 0x32 0x0D 0x0A); `Overflow` stays 0.
- Input "0007\r\n" then "0\r" → "7\r\n" then "0\r\n"; the LF is absorbed with no output.
- Input "99999\r" → "65535\r\n"; `Overflow` pulses exactly once, in the cycle after the LF handshake.
- Input "1a2\r" → "?\r\n". A following empty line "\r" → "\r\n".
- Input "31415\r" with `DataOutReady` toggled randomly (50%) and `DataInValid` held high:
  - Output is exactly "31415\r\n".
  - `DataOut` never changes while stalled.
  - `DataInReady`=0 until the LF is accepted.
- Pulse `Reset_n` low during the CONV of "12345\r" → outputs 0 immediately. After release and one RST cycle, `DataInReady`=1; "8\r" → "8\r\n".
